// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM port arbiter.
// Owner tags double as FSM state and in-flight read tags.
package vram_arb_pkg;

    localparam int VRAM_DEPTH = 90000;
    localparam int VRAM_AW    = 17;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_CPU
    } owner_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/vram_arb_stats.sv
// Saturating grant/stall counters for the VRAM arbiter.
// Present only in builds with VRAM_ARB_STATS_EN defined.
module vram_arb_stats
    import vram_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  owner_e      state,
    input  logic        cpu_req,
    input  logic        cpu_gnt,
    output logic [31:0] stat_disp_gnt,
    output logic [31:0] stat_cpu_gnt,
    output logic [31:0] stat_cpu_stall
);

    // Grant counts follow the last-owner state, one cycle behind the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_disp_gnt  <= '0;
            stat_cpu_gnt   <= '0;
            stat_cpu_stall <= '0;
        end else begin
            if (state == OWN_DISP)
                stat_disp_gnt <= sat_inc(stat_disp_gnt);
            if (state == OWN_CPU)
                stat_cpu_gnt <= sat_inc(stat_cpu_gnt);
            if (cpu_req && !cpu_gnt)
                stat_cpu_stall <= sat_inc(stat_cpu_stall);
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Display-priority arbiter for the single-port image VRAM with CPU starvation guard.
// Optional counters: define VRAM_ARB_STATS_EN.
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MEM_AW       = vram_arb_pkg::VRAM_AW,
    parameter int DATA_W       = 8,
    parameter int VRAM_DEPTH   = vram_arb_pkg::VRAM_DEPTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              addr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_disp_gnt,
    output logic [31:0]       stat_cpu_gnt,
    output logic [31:0]       stat_cpu_stall
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]     streak;
    logic              starve;
    logic              any_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic              in_range;
    owner_e            rd_tag;
    owner_e            tag1, tag2;
    logic              oor1, oor2;
    logic [DATA_W-1:0] rdata_now;
    logic [DATA_W-1:0] disp_hold, cpu_hold;

    always_comb begin
        starve   = cpu_req && (streak == SW'(STARVE_LIMIT));
        disp_gnt = disp_req && !starve;
        cpu_gnt  = cpu_req && !disp_gnt;
        any_gnt  = disp_gnt || cpu_gnt;
        sel_addr = disp_gnt ? disp_addr : cpu_addr;
        in_range = sel_addr < ADDR_W'(VRAM_DEPTH);
        rd_tag   = OWN_NONE;
        if (disp_gnt)
            rd_tag = OWN_DISP;
        else if (cpu_gnt && !cpu_we)
            rd_tag = OWN_CPU;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            streak <= '0;
        else if (!cpu_req || cpu_gnt)
            streak <= '0;
        else if (disp_gnt && streak != SW'(STARVE_LIMIT))
            streak <= streak + SW'(1);
    end

    // Out-of-range requests are granted but never reach the macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            addr_err  <= 1'b0;
            tag1      <= OWN_NONE;
            oor1      <= 1'b0;
            tag2      <= OWN_NONE;
            oor2      <= 1'b0;
        end else begin
            mem_en   <= any_gnt && in_range;
            mem_we   <= cpu_gnt && cpu_we && in_range;
            addr_err <= any_gnt && !in_range;
            if (any_gnt)
                mem_addr <= sel_addr[MEM_AW-1:0];
            if (cpu_gnt)
                mem_wdata <= cpu_wdata;
            tag1 <= rd_tag;
            oor1 <= !in_range;
            tag2 <= tag1;
            oor2 <= oor1;
        end
    end

    always_comb begin
        rdata_now   = oor2 ? '0 : mem_rdata;
        disp_rvalid = (tag2 == OWN_DISP);
        cpu_rvalid  = (tag2 == OWN_CPU);
        disp_rdata  = disp_rvalid ? rdata_now : disp_hold;
        cpu_rdata   = cpu_rvalid ? rdata_now : cpu_hold;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_hold <= '0;
            cpu_hold  <= '0;
        end else begin
            if (disp_rvalid)
                disp_hold <= rdata_now;
            if (cpu_rvalid)
                cpu_hold <= rdata_now;
        end
    end

`ifdef VRAM_ARB_STATS_EN
    owner_e state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= OWN_NONE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = OWN_NONE;
        if (disp_gnt)
            state_d = OWN_DISP;
        else if (cpu_gnt)
            state_d = OWN_CPU;
    end

    vram_arb_stats u_stats (
        .clk            (clk),
        .reset          (reset),
        .state          (state_q),
        .cpu_req        (cpu_req),
        .cpu_gnt        (cpu_gnt),
        .stat_disp_gnt  (stat_disp_gnt),
        .stat_cpu_gnt   (stat_cpu_gnt),
        .stat_cpu_stall (stat_cpu_stall)
    );
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed self-checking bench for vram_port_arbiter with a behavioural VRAM.
// Stats checks run only when VRAM_ARB_STATS_EN is defined.
module tb_vram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        disp_req = 1'b0;
    logic [31:0] disp_addr = '0;
    logic        disp_gnt, disp_rvalid;
    logic [7:0]  disp_rdata;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        addr_err, mem_en, mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
`ifdef VRAM_ARB_STATS_EN
    logic [31:0] stat_disp_gnt, stat_cpu_gnt, stat_cpu_stall;
`endif

    int total = 0;
    int bad = 0;

    logic [7:0] vram [0:131071];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                vram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= vram[mem_addr];
        end
    end

    vram_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .addr_err    (addr_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stat_disp_gnt  (stat_disp_gnt),
        .stat_cpu_gnt   (stat_cpu_gnt),
        .stat_cpu_stall (stat_cpu_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {30'd0, disp_gnt, cpu_gnt}, 32'd0);
        chk({tag, "_rv"}, {30'd0, disp_rvalid, cpu_rvalid}, 32'd0);
        chk({tag, "_rdata"}, {16'd0, disp_rdata, cpu_rdata}, 32'd0);
        chk({tag, "_mem"}, {29'd0, addr_err, mem_en, mem_we}, 32'd0);
        chk({tag, "_maddr"}, {15'd0, mem_addr}, 32'd0);
        chk({tag, "_mwdata"}, {24'd0, mem_wdata}, 32'd0);
    endtask

    initial begin
        mem_rdata = 8'h00;
        // 1: reset
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_en0", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        chk("idle_en1", {31'd0, mem_en}, 32'd0);

        // 2: CPU write then read of addr 5
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 8'hA5;
        #1 chk("wr_gnt", {30'd0, disp_gnt, cpu_gnt}, 32'd1);
        @(negedge clk);
        chk("wr_mem", {29'd0, mem_en, mem_we, addr_err}, 32'b110);
        chk("wr_addr", {15'd0, mem_addr}, 32'd5);
        chk("wr_data", {24'd0, mem_wdata}, 32'hA5);
        cpu_we = 1'b0;
        #1 chk("rd_gnt", {31'd0, cpu_gnt}, 32'd1);
        @(negedge clk);
        cpu_req = 1'b0;
        chk("rd_mem", {30'd0, mem_en, mem_we}, 32'b10);
        chk("rd_early", {31'd0, cpu_rvalid}, 32'd0);
        @(negedge clk);
        chk("rd_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk("rd_rdata", {24'd0, cpu_rdata}, 32'hA5);
        @(negedge clk);
        chk("rd_rv_off", {31'd0, cpu_rvalid}, 32'd0);
        chk("rd_hold", {24'd0, cpu_rdata}, 32'hA5);

        // 3: starvation guard, pattern D,D,D,D,C
        disp_req = 1'b1; disp_addr = 32'd5;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd20; cpu_wdata = 8'h11;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i % 5 == 4)
                chk($sformatf("pat%0d", i), {30'd0, disp_gnt, cpu_gnt}, 32'b01);
            else
                chk($sformatf("pat%0d", i), {30'd0, disp_gnt, cpu_gnt}, 32'b10);
            if (i == 2)
                chk("pat_drd", {23'd0, disp_rvalid, disp_rdata}, {23'd0, 1'b1, 8'hA5});
            if (i == 6)
                chk("pat_norv", {31'd0, disp_rvalid}, 32'd0);
            @(negedge clk);
        end
        disp_req = 1'b0; cpu_req = 1'b0;
        repeat (3) @(negedge clk);

        // 4: out-of-range write and read at 90000
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd90000; cpu_wdata = 8'h77;
        #1 chk("oor_wgnt", {31'd0, cpu_gnt}, 32'd1);
        @(negedge clk);
        chk("oor_w", {30'd0, addr_err, mem_en}, 32'b10);
        cpu_we = 1'b0;
        #1 chk("oor_rgnt", {31'd0, cpu_gnt}, 32'd1);
        @(negedge clk);
        cpu_req = 1'b0;
        chk("oor_r", {30'd0, addr_err, mem_en}, 32'b10);
        @(negedge clk);
        chk("oor_rv", {22'd0, addr_err, cpu_rvalid, cpu_rdata}, {22'd0, 1'b0, 1'b1, 8'h00});

        // 5: reset during an in-flight display read
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 32'd5;
        #1 chk("rst_dgnt", {31'd0, disp_gnt}, 32'd1);
        @(negedge clk);
        disp_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk_all_zero("rst2");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst_norv%0d", i), {31'd0, disp_rvalid}, 32'd0);
        end

`ifdef VRAM_ARB_STATS_EN
        // 6: counters over 20 contended cycles
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("st_rst", stat_disp_gnt | stat_cpu_gnt | stat_cpu_stall, 32'd0);
        disp_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
        repeat (20) @(negedge clk);
        disp_req = 1'b0; cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("st_disp", stat_disp_gnt, 32'd16);
        chk("st_cpu", stat_cpu_gnt, 32'd4);
        chk("st_stall", stat_cpu_stall, 32'd16);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
